musa_stage_sequencer: RTL

//  Multicycle stage sequencer for the MUSA core; replaces free-running stage counting.

---
 rtl/musa_pkg.sv | 27 ++
 rtl/musa_stage_sequencer_if.sv | 10 +
 rtl/musa_op_class.sv | 23 ++
 rtl/musa_stage_sequencer.sv | 84 ++++++++
 4 files changed

// File: rtl/musa_pkg.sv
// musa_pkg: stage encodings, opcode constants and opcode classes for the MUSA stage sequencer.
package musa_pkg;
  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EX   = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101,
    ST_IDLE = 3'b110
  } stage_e;
  typedef enum logic [2:0] {CLS_ALU, CLS_LOAD, CLS_STORE, CLS_JMP, CLS_STK, CLS_NOP, CLS_HALT} cls_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_NOP   = 6'b000001;
  localparam logic [5:0] OP_HALT  = 6'b000010;
  localparam logic [5:0] OP_CALL  = 6'b000011;
  localparam logic [5:0] OP_RET   = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_JPC   = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SUBI  = 6'b001110;
  localparam logic [5:0] OP_JR    = 6'b010000;
  localparam logic [5:0] OP_BRFL  = 6'b010001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
endpackage

// File: rtl/musa_stage_sequencer_if.sv
// musa_stage_sequencer_if: instruction/data memory handshake between sequencer and memories.
interface musa_stage_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;
  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/musa_op_class.sv
// musa_op_class: combinational opcode -> class decode with undefined-opcode flag.
module musa_op_class
  import musa_pkg::*;
(
  input  logic [5:0] opcode,
  output cls_e       cls,
  output logic       illegal
);
  always_comb begin
    cls = CLS_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: cls = CLS_ALU;
      OP_LW: cls = CLS_LOAD;
      OP_SW: cls = CLS_STORE;
      OP_JPC, OP_JR, OP_BRFL: cls = CLS_JMP;
      OP_CALL, OP_RET: cls = CLS_STK;
      OP_NOP: cls = CLS_NOP;
      OP_HALT: cls = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/musa_stage_sequencer.sv
// musa_stage_sequencer: steps each instruction through IF/ID/EX/MEM/WB per opcode class, issuing datapath strobes.
module musa_stage_sequencer
  import musa_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic [5:0]                 opcode,
  input  logic                       alu_busy,
  musa_stage_sequencer_if.master     mem,
  output logic [2:0]                 stage,
  output logic                       ir_we,
  output logic                       pc_we,
  output logic                       pc_sel,
  output logic                       rf_we,
  output logic                       instr_done,
  output logic                       illegal,
  output logic                       halted,
  output logic [CNT_W-1:0]           retired
);
  logic [1:0] rst_sync_q, rst_sync_d;
  stage_e state_q, state_d, next_st;
  logic [5:0] op_q, op_d, op_sel;
  logic [CNT_W-1:0] retired_q, retired_d;
  cls_e cls;
  logic bad, ex_go, mem_go, jump, ls;
  // Opcode is only valid from ID on; afterwards the latched copy drives the class.
  assign op_sel = (state_q == ST_ID) ? opcode : op_q;
  musa_op_class u_op_class (.opcode(op_sel), .cls(cls), .illegal(bad));
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    ex_go = state_q == ST_EX && !alu_busy;
    mem_go = state_q == ST_MEM && mem.dmem_ack;
    jump = ex_go && (cls == CLS_JMP || cls == CLS_STK);
    ls = cls == CLS_LOAD || cls == CLS_STORE;
    instr_done = (state_q == ST_ID && (cls == CLS_NOP || cls == CLS_HALT)) || jump
                 || (mem_go && cls == CLS_STORE) || state_q == ST_WB;
    next_st = run ? ST_IF : ST_IDLE;
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = run ? ST_IF : ST_IDLE;
      ST_IF:   state_d = mem.imem_ack ? ST_ID : ST_IF;
      ST_ID:   state_d = cls == CLS_HALT ? ST_HALT : instr_done ? next_st : ST_EX;
      ST_EX:   state_d = alu_busy ? ST_EX : cls == CLS_ALU ? ST_WB : ls ? ST_MEM : next_st;
      ST_MEM:  state_d = !mem.dmem_ack ? ST_MEM : cls == CLS_LOAD ? ST_WB : next_st;
      ST_WB:   state_d = next_st;
      default: state_d = state_q;
    endcase
    op_d = op_sel;
    retired_d = retired_q + CNT_W'(instr_done);
    // Release from reset is held off until the synchroniser has seen rst_n high for two edges.
    if (!rst_sync_q[1]) begin
      state_d = ST_IDLE;
      op_d = '0;
      retired_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
      state_q <= ST_IDLE;
      op_q <= '0;
      retired_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
      state_q <= state_d;
      op_q <= op_d;
      retired_q <= retired_d;
    end
  end
  assign stage = state_q;
  assign mem.imem_req = state_q == ST_IF;
  assign ir_we = state_q == ST_IF && mem.imem_ack;
  assign pc_we = ir_we || jump;
  assign pc_sel = jump;
  assign mem.dmem_req = state_q == ST_MEM;
  assign mem.dmem_we = state_q == ST_MEM && cls == CLS_STORE;
  assign rf_we = state_q == ST_WB;
  assign illegal = state_q == ST_ID && bad;
  assign halted = state_q == ST_HALT;
  assign retired = retired_q;
endmodule
